// File: rtl/memex_load_store_unit_if.sv
// ----------------------------------------------------------------------------
// memex_load_store_unit_if
// Purpose : single-outstanding data-memory bus between the MEMEX load/store
//           unit (master) and the memory/bus fabric (slave).
// Signals : bus_req   - request strobe, held for the whole access
//           bus_we    - 1 = write, 0 = read
//           bus_addr  - word-aligned byte address (bits [1:0] = 00)
//           bus_wdata - lane-replicated store data
//           bus_wstrb - byte enables (0000 for reads)
//           bus_ack   - completion; bus_rdata valid in the same cycle
//           bus_rdata - read word
// ----------------------------------------------------------------------------
interface memex_load_store_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/memex_load_store_unit.sv
// ----------------------------------------------------------------------------
// memex_load_store_unit
// Purpose : MEMEX-stage load/store unit. Decodes the access, flags misaligned
//           accesses, issues one bus transaction at a time through an
//           IDLE -> BUSY -> DONE sequence, stalls the pipeline while the
//           access is outstanding, aligns/extends load data and raises a
//           bus fault when the slave fails to acknowledge in time.
// Ports   : clk, rst            - clock, synchronous active-high reset
//           invalid_MEMEX       - bubble flag (1 = no access)
//           mem_op_MEMEX        - 01 load, 10 store, others none
//           funct3_MEMEX        - access size / signedness
//           addr_MEMEX          - byte address
//           store_data_MEMEX    - store source value
//           bus                 - data bus, master side
//           load_data_MEMEX     - aligned, extended load result (DONE only)
//           stall_MEMEX         - hold MEMEX and upstream stages
//           misaligned_MEMEX    - misaligned access exception
//           bus_fault_MEMEX     - bus timeout exception (DONE only)
// Params  : TIMEOUT_CYCLES      - BUSY cycles without ack before fault (1..255)
// ----------------------------------------------------------------------------
module memex_load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            invalid_MEMEX,
    input  logic [1:0]                      mem_op_MEMEX,
    input  logic [2:0]                      funct3_MEMEX,
    input  logic [31:0]                     addr_MEMEX,
    input  logic [31:0]                     store_data_MEMEX,
    memex_load_store_unit_if.master         bus,
    output logic [31:0]                     load_data_MEMEX,
    output logic                            stall_MEMEX,
    output logic                            misaligned_MEMEX,
    output logic                            bus_fault_MEMEX
);

    localparam logic [7:0] TIMEOUT_W = TIMEOUT_CYCLES[7:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e      state_q;
    logic [7:0]  wdog_q;
    logic        fault_q;
    logic        bus_req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [31:0] rdata_q;

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    logic is_load, is_store, legal, misalign, mem_req, access;

    assign is_load  = (mem_op_MEMEX == 2'b01);
    assign is_store = (mem_op_MEMEX == 2'b10);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise an uncovered case path infers a latch.
        legal = 1'b0;
        if (is_load) begin
            legal = (funct3_MEMEX == 3'b000) || (funct3_MEMEX == 3'b001) ||
                    (funct3_MEMEX == 3'b010) || (funct3_MEMEX == 3'b100) ||
                    (funct3_MEMEX == 3'b101);
        end else if (is_store) begin
            legal = (funct3_MEMEX == 3'b000) || (funct3_MEMEX == 3'b001) ||
                    (funct3_MEMEX == 3'b010);
        end
    end

    // funct3[1:0] encodes the size for every legal code: 00 byte, 01 half, 10 word.
    assign misalign = ((funct3_MEMEX[1:0] == 2'b01) && addr_MEMEX[0]) ||
                      ((funct3_MEMEX[1:0] == 2'b10) && (addr_MEMEX[1:0] != 2'b00));

    assign mem_req = !invalid_MEMEX && (is_load || is_store) && legal;
    assign access  = mem_req && !misalign;

    assign misaligned_MEMEX = (state_q == S_IDLE) && mem_req && misalign;
    assign stall_MEMEX      = ((state_q == S_IDLE) && access) || (state_q == S_BUSY);

    // ------------------------------------------------------------------
    // Store lane steering (captured on entry to BUSY)
    // ------------------------------------------------------------------
    logic [3:0]  wstrb_d;
    logic [31:0] wdata_d;

    always_comb begin
        wstrb_d = 4'b0000;
        wdata_d = 32'h0;
        if (is_store) begin
            case (funct3_MEMEX[1:0])
                2'b00: begin
                    wstrb_d = 4'b0001 << addr_MEMEX[1:0];
                    wdata_d = {4{store_data_MEMEX[7:0]}};
                end
                2'b01: begin
                    wstrb_d = 4'b0011 << {addr_MEMEX[1], 1'b0};
                    wdata_d = {2{store_data_MEMEX[15:0]}};
                end
                default: begin
                    wstrb_d = 4'b1111;
                    wdata_d = store_data_MEMEX;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Load extraction from the captured read word
    // ------------------------------------------------------------------
    logic [31:0] rsh_b, rsh_h, ext;

    always_comb begin
        rsh_b = rdata_q >> {off_q, 3'b000};
        rsh_h = rdata_q >> {off_q[1], 4'b0000};
        case (funct3_q)
            3'b000:  ext = {{24{rsh_b[7]}}, rsh_b[7:0]};
            3'b001:  ext = {{16{rsh_h[15]}}, rsh_h[15:0]};
            3'b010:  ext = rdata_q;
            3'b100:  ext = {24'h0, rsh_b[7:0]};
            3'b101:  ext = {16'h0, rsh_h[15:0]};
            default: ext = 32'h0;
        endcase
    end

    assign load_data_MEMEX = ((state_q == S_DONE) && !we_q) ? ext : 32'h0;
    assign bus_fault_MEMEX = (state_q == S_DONE) && fault_q;

    // Bus outputs come only from captured registers and are zero outside BUSY.
    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_req_q && we_q;
    assign bus.bus_addr  = bus_req_q ? addr_q  : 32'h0;
    assign bus.bus_wdata = bus_req_q ? wdata_q : 32'h0;
    assign bus.bus_wstrb = bus_req_q ? wstrb_q : 4'b0000;

    // ------------------------------------------------------------------
    // Access sequencer
    // ------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the captured request/response registers are reset too,
            // so nothing stale can appear on the bus or load result.
            state_q   <= S_IDLE;
            wdog_q    <= 8'd0;
            fault_q   <= 1'b0;
            bus_req_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            wstrb_q   <= 4'b0000;
            funct3_q  <= 3'b000;
            off_q     <= 2'b00;
            rdata_q   <= 32'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (access) begin
                        addr_q    <= {addr_MEMEX[31:2], 2'b00};
                        we_q      <= is_store;
                        wdata_q   <= wdata_d;
                        wstrb_q   <= wstrb_d;
                        funct3_q  <= funct3_MEMEX;
                        off_q     <= addr_MEMEX[1:0];
                        rdata_q   <= 32'h0;
                        wdog_q    <= 8'd0;
                        fault_q   <= 1'b0;
                        bus_req_q <= 1'b1;
                        state_q   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // Ack wins over a timeout landing in the same cycle.
                    if (bus.bus_ack) begin
                        rdata_q   <= bus.bus_rdata;
                        wdog_q    <= 8'd0;
                        bus_req_q <= 1'b0;
                        state_q   <= S_DONE;
                    end else if (wdog_q == TIMEOUT_W) begin
                        fault_q   <= 1'b1;
                        wdog_q    <= 8'd0;
                        bus_req_q <= 1'b0;
                        state_q   <= S_DONE;
                    end else begin
                        wdog_q    <= wdog_q + 8'd1;
                    end
                end
                S_DONE: begin
                    fault_q <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    bus_req_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memex_load_store_unit.sv
module tb_memex_load_store_unit;

    logic        clk;
    logic        rst;
    logic        invalid_MEMEX;
    logic [1:0]  mem_op_MEMEX;
    logic [2:0]  funct3_MEMEX;
    logic [31:0] addr_MEMEX;
    logic [31:0] store_data_MEMEX;
    logic [31:0] load_data_MEMEX;
    logic        stall_MEMEX;
    logic        misaligned_MEMEX;
    logic        bus_fault_MEMEX;

    int vectors;
    int miscompares;

    memex_load_store_unit_if bus_if ();

    memex_load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .invalid_MEMEX    (invalid_MEMEX),
        .mem_op_MEMEX     (mem_op_MEMEX),
        .funct3_MEMEX     (funct3_MEMEX),
        .addr_MEMEX       (addr_MEMEX),
        .store_data_MEMEX (store_data_MEMEX),
        .bus              (bus_if),
        .load_data_MEMEX  (load_data_MEMEX),
        .stall_MEMEX      (stall_MEMEX),
        .misaligned_MEMEX (misaligned_MEMEX),
        .bus_fault_MEMEX  (bus_fault_MEMEX)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        invalid_MEMEX = 1'b1;
        mem_op_MEMEX  = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        funct3_MEMEX     = 3'b000;
        addr_MEMEX       = 32'h0;
        store_data_MEMEX = 32'h0;
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = 32'h0;
        next_cycle();
        next_cycle();
        vectors++; if (bus_if.bus_req !== 1'b0) begin miscompares++; $display("FAIL reset bus_req: got %b want 0", bus_if.bus_req); end
        vectors++; if (bus_if.bus_we !== 1'b0) begin miscompares++; $display("FAIL reset bus_we: got %b want 0", bus_if.bus_we); end
        vectors++; if (bus_if.bus_addr !== 32'h0) begin miscompares++; $display("FAIL reset bus_addr: got %h want 0", bus_if.bus_addr); end
        vectors++; if (bus_if.bus_wdata !== 32'h0) begin miscompares++; $display("FAIL reset bus_wdata: got %h want 0", bus_if.bus_wdata); end
        vectors++; if (bus_if.bus_wstrb !== 4'h0) begin miscompares++; $display("FAIL reset bus_wstrb: got %b want 0", bus_if.bus_wstrb); end
        vectors++; if (load_data_MEMEX !== 32'h0) begin miscompares++; $display("FAIL reset load_data: got %h want 0", load_data_MEMEX); end
        vectors++; if (stall_MEMEX !== 1'b0) begin miscompares++; $display("FAIL reset stall: got %b want 0", stall_MEMEX); end
        vectors++; if (misaligned_MEMEX !== 1'b0) begin miscompares++; $display("FAIL reset misaligned: got %b want 0", misaligned_MEMEX); end
        vectors++; if (bus_fault_MEMEX !== 1'b0) begin miscompares++; $display("FAIL reset bus_fault: got %b want 0", bus_fault_MEMEX); end
        rst = 1'b0;
        next_cycle();
        vectors++; if (bus_if.bus_req !== 1'b0) begin miscompares++; $display("FAIL post_reset bus_req: got %b want 0", bus_if.bus_req); end
    endtask

    // One complete access starting in IDLE. ack arrives after ack_wait BUSY
    // cycles without it; inputs are scrambled during BUSY to prove capture.
    task automatic do_access(input string name, input logic [1:0] op, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] sdata,
                             input logic [31:0] rdata, input int ack_wait,
                             input logic exp_we, input logic [31:0] exp_addr,
                             input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata,
                             input logic [31:0] exp_load);
        int stalls;
        stalls = 0;
        invalid_MEMEX    = 1'b0;
        mem_op_MEMEX     = op;
        funct3_MEMEX     = f3;
        addr_MEMEX       = addr;
        store_data_MEMEX = sdata;
        #1;
        if (stall_MEMEX) stalls++;
        vectors++; if (misaligned_MEMEX !== 1'b0) begin miscompares++; $display("FAIL %s idle misaligned: got %b want 0", name, misaligned_MEMEX); end
        vectors++; if (bus_if.bus_req !== 1'b0) begin miscompares++; $display("FAIL %s idle bus_req: got %b want 0", name, bus_if.bus_req); end
        next_cycle();
        if (stall_MEMEX) stalls++;
        addr_MEMEX       = ~addr;
        store_data_MEMEX = ~sdata;
        funct3_MEMEX     = ~f3;
        #1;
        vectors++; if (bus_if.bus_req !== 1'b1) begin miscompares++; $display("FAIL %s busy bus_req: got %b want 1", name, bus_if.bus_req); end
        vectors++; if (bus_if.bus_we !== exp_we) begin miscompares++; $display("FAIL %s bus_we: got %b want %b", name, bus_if.bus_we, exp_we); end
        vectors++; if (bus_if.bus_addr !== exp_addr) begin miscompares++; $display("FAIL %s bus_addr: got %h want %h", name, bus_if.bus_addr, exp_addr); end
        vectors++; if (bus_if.bus_wstrb !== exp_wstrb) begin miscompares++; $display("FAIL %s bus_wstrb: got %b want %b", name, bus_if.bus_wstrb, exp_wstrb); end
        if (exp_we) begin
            vectors++; if (bus_if.bus_wdata !== exp_wdata) begin miscompares++; $display("FAIL %s bus_wdata: got %h want %h", name, bus_if.bus_wdata, exp_wdata); end
        end
        for (int i = 0; i < ack_wait; i++) begin
            next_cycle();
            if (stall_MEMEX) stalls++;
            vectors++; if (bus_if.bus_req !== 1'b1 || bus_if.bus_addr !== exp_addr || bus_if.bus_wstrb !== exp_wstrb) begin
                miscompares++; $display("FAIL %s hold%0d: got req %b addr %h strb %b want 1 %h %b", name, i, bus_if.bus_req, bus_if.bus_addr, bus_if.bus_wstrb, exp_addr, exp_wstrb);
            end
        end
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = rdata;
        next_cycle();
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = 32'hA5A5_A5A5;
        drive_idle();
        #1;
        if (stall_MEMEX) stalls++;
        vectors++; if (stalls !== ack_wait + 2) begin miscompares++; $display("FAIL %s stall cycles: got %0d want %0d", name, stalls, ack_wait + 2); end
        vectors++; if (bus_if.bus_req !== 1'b0) begin miscompares++; $display("FAIL %s done bus_req: got %b want 0", name, bus_if.bus_req); end
        vectors++; if (load_data_MEMEX !== exp_load) begin miscompares++; $display("FAIL %s load_data: got %h want %h", name, load_data_MEMEX, exp_load); end
        vectors++; if (bus_fault_MEMEX !== 1'b0) begin miscompares++; $display("FAIL %s bus_fault: got %b want 0", name, bus_fault_MEMEX); end
        next_cycle();
        vectors++; if (load_data_MEMEX !== 32'h0) begin miscompares++; $display("FAIL %s idle load_data: got %h want 0", name, load_data_MEMEX); end
    endtask

    task automatic test_loads();
        do_access("lb_1003",  2'b01, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 1'b0, 32'h0000_1000, 4'h0, 32'h0, 32'hFFFF_FF80);
        do_access("lh_7002",  2'b01, 3'b001, 32'h0000_7002, 32'h0, 32'h8001_1234, 1, 1'b0, 32'h0000_7000, 4'h0, 32'h0, 32'hFFFF_8001);
        do_access("lbu_7001", 2'b01, 3'b100, 32'h0000_7001, 32'h0, 32'h0000_F200, 0, 1'b0, 32'h0000_7000, 4'h0, 32'h0, 32'h0000_00F2);
        do_access("lhu_7000", 2'b01, 3'b101, 32'h0000_7000, 32'h0, 32'h1234_ABCD, 2, 1'b0, 32'h0000_7000, 4'h0, 32'h0, 32'h0000_ABCD);
        do_access("lb_7002",  2'b01, 3'b000, 32'h0000_7002, 32'h0, 32'h007F_0000, 0, 1'b0, 32'h0000_7000, 4'h0, 32'h0, 32'h0000_007F);
        do_access("lh_7000",  2'b01, 3'b001, 32'h0000_7000, 32'h0, 32'h0000_7FFE, 0, 1'b0, 32'h0000_7000, 4'h0, 32'h0, 32'h0000_7FFE);
    endtask

    task automatic test_stores();
        do_access("sh_2002", 2'b10, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 32'hFFFF_FFFF, 2, 1'b1, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 32'h0);
        do_access("sh_2000", 2'b10, 3'b001, 32'h0000_2000, 32'hFFFF_1234, 32'hFFFF_FFFF, 0, 1'b1, 32'h0000_2000, 4'b0011, 32'h1234_1234, 32'h0);
        do_access("sb_5001", 2'b10, 3'b000, 32'h0000_5001, 32'h1234_5678, 32'hFFFF_FFFF, 1, 1'b1, 32'h0000_5000, 4'b0010, 32'h7878_7878, 32'h0);
        do_access("sb_5003", 2'b10, 3'b000, 32'h0000_5003, 32'h0000_00A5, 32'hFFFF_FFFF, 0, 1'b1, 32'h0000_5000, 4'b1000, 32'hA5A5_A5A5, 32'h0);
        do_access("sw_6004", 2'b10, 3'b010, 32'h0000_6004, 32'hCAFE_F00D, 32'hFFFF_FFFF, 0, 1'b1, 32'h0000_6004, 4'b1111, 32'hCAFE_F00D, 32'h0);
    endtask

    // Ack on the very cycle the watchdog reaches its limit must win.
    task automatic test_ack_at_timeout();
        do_access("lw_ack_at_limit", 2'b01, 3'b010, 32'h0000_7008, 32'h0, 32'hDEAD_BEEF, 4, 1'b0, 32'h0000_7008, 4'h0, 32'h0, 32'hDEAD_BEEF);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic        exp_mis;
    } nacc_t;

    task automatic test_no_access();
        nacc_t v [8];
        v[0] = '{2'b01, 3'b010, 32'h0000_3001, 1'b1};  // LW
        v[1] = '{2'b01, 3'b001, 32'h0000_3001, 1'b1};  // LH
        v[2] = '{2'b01, 3'b101, 32'h0000_3003, 1'b1};  // LHU
        v[3] = '{2'b10, 3'b010, 32'h0000_3002, 1'b1};  // SW
        v[4] = '{2'b10, 3'b001, 32'h0000_3001, 1'b1};  // SH
        v[5] = '{2'b01, 3'b011, 32'h0000_3001, 1'b0};  // illegal load funct3
        v[6] = '{2'b10, 3'b100, 32'h0000_3001, 1'b0};  // illegal store funct3
        v[7] = '{2'b11, 3'b010, 32'h0000_3001, 1'b0};  // op 11
        for (int i = 0; i < 8; i++) begin
            invalid_MEMEX = 1'b0;
            mem_op_MEMEX  = v[i].op;
            funct3_MEMEX  = v[i].f3;
            addr_MEMEX    = v[i].addr;
            #1;
            vectors++; if (misaligned_MEMEX !== v[i].exp_mis) begin miscompares++; $display("FAIL noacc%0d misaligned: got %b want %b", i, misaligned_MEMEX, v[i].exp_mis); end
            vectors++; if (stall_MEMEX !== 1'b0) begin miscompares++; $display("FAIL noacc%0d stall: got %b want 0", i, stall_MEMEX); end
            next_cycle();
            vectors++; if (bus_if.bus_req !== 1'b0) begin miscompares++; $display("FAIL noacc%0d bus_req: got %b want 0", i, bus_if.bus_req); end
        end
        drive_idle();
        next_cycle();
    endtask

    task automatic test_timeout();
        int req_cycles;
        req_cycles = 0;
        invalid_MEMEX = 1'b0;
        mem_op_MEMEX  = 2'b01;
        funct3_MEMEX  = 3'b101;
        addr_MEMEX    = 32'h0000_4002;
        #1;
        vectors++; if (stall_MEMEX !== 1'b1) begin miscompares++; $display("FAIL timeout idle stall: got %b want 1", stall_MEMEX); end
        next_cycle();
        drive_idle();
        for (int i = 0; i < 20; i++) begin
            if (!bus_if.bus_req) break;
            req_cycles++;
            next_cycle();
        end
        vectors++; if (req_cycles !== 5) begin miscompares++; $display("FAIL timeout bus_req cycles: got %0d want 5", req_cycles); end
        vectors++; if (bus_fault_MEMEX !== 1'b1) begin miscompares++; $display("FAIL timeout bus_fault: got %b want 1", bus_fault_MEMEX); end
        vectors++; if (load_data_MEMEX !== 32'h0) begin miscompares++; $display("FAIL timeout load_data: got %h want 0", load_data_MEMEX); end
        vectors++; if (stall_MEMEX !== 1'b0) begin miscompares++; $display("FAIL timeout done stall: got %b want 0", stall_MEMEX); end
        next_cycle();
        vectors++; if (bus_fault_MEMEX !== 1'b0) begin miscompares++; $display("FAIL timeout idle bus_fault: got %b want 0", bus_fault_MEMEX); end
    endtask

    task automatic test_invalid_and_reset_in_busy();
        invalid_MEMEX = 1'b1;
        mem_op_MEMEX  = 2'b01;
        funct3_MEMEX  = 3'b010;
        addr_MEMEX    = 32'h0000_8000;
        #1;
        vectors++; if (stall_MEMEX !== 1'b0) begin miscompares++; $display("FAIL invalid stall: got %b want 0", stall_MEMEX); end
        next_cycle();
        vectors++; if (bus_if.bus_req !== 1'b0) begin miscompares++; $display("FAIL invalid bus_req: got %b want 0", bus_if.bus_req); end
        invalid_MEMEX = 1'b0;
        #1;
        vectors++; if (stall_MEMEX !== 1'b1) begin miscompares++; $display("FAIL rstbusy idle stall: got %b want 1", stall_MEMEX); end
        next_cycle();
        vectors++; if (bus_if.bus_req !== 1'b1) begin miscompares++; $display("FAIL rstbusy bus_req: got %b want 1", bus_if.bus_req); end
        rst = 1'b1;
        drive_idle();
        next_cycle();
        vectors++; if (bus_if.bus_req !== 1'b0) begin miscompares++; $display("FAIL rstbusy after reset bus_req: got %b want 0", bus_if.bus_req); end
        vectors++; if (stall_MEMEX !== 1'b0) begin miscompares++; $display("FAIL rstbusy after reset stall: got %b want 0", stall_MEMEX); end
        rst = 1'b0;
        next_cycle();
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 32'h1357_9BDF;
        next_cycle();
        bus_if.bus_ack = 1'b0;
        #1;
        vectors++; if (bus_if.bus_req !== 1'b0 || stall_MEMEX !== 1'b0) begin miscompares++; $display("FAIL stray ack req/stall: got %b/%b want 0/0", bus_if.bus_req, stall_MEMEX); end
        vectors++; if (load_data_MEMEX !== 32'h0 || bus_fault_MEMEX !== 1'b0) begin miscompares++; $display("FAIL stray ack load/fault: got %h/%b want 0/0", load_data_MEMEX, bus_fault_MEMEX); end
        next_cycle();
        vectors++; if (load_data_MEMEX !== 32'h0 || bus_if.bus_req !== 1'b0) begin miscompares++; $display("FAIL stray ack later: got load %h req %b want 0 0", load_data_MEMEX, bus_if.bus_req); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_loads();
        test_stores();
        test_ack_at_timeout();
        test_no_access();
        test_timeout();
        test_invalid_and_reset_in_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/memex_load_store_unit.md
MEMEX_LOAD_STORE_UNIT -- requirements
Module: memex_load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max BUSY cycles without bus_ack before fault (1..255).
REQ-002 SHALL have port clk  in  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port invalid_MEMEX  in  1  bubble flag; 1 = no access.
REQ-005 SHALL have port mem_op_MEMEX  in  2  00 none, 01 load, 10 store, 11 none.
REQ-006 SHALL have port funct3_MEMEX  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 SHALL have port addr_MEMEX  in  32  byte address (ALU result).
REQ-008 SHALL have port store_data_MEMEX  in  32  rs2 value.
REQ-009 SHALL have port bus_req  out  1  request strobe, registered.
REQ-010 SHALL have port bus_we  out  1  1 = write.
REQ-011 SHALL have port bus_addr  out  32  word address, bits[1:0] = 00.
REQ-012 SHALL have port bus_wdata  out  32  lane-replicated store data.
REQ-013 SHALL have port bus_wstrb  out  4  byte enables; 0000 for loads.
REQ-014 SHALL have port bus_ack  in  1  completion; bus_rdata valid same cycle.
REQ-015 SHALL have port bus_rdata  in  32  read word.
REQ-016 SHALL have port load_data_MEMEX  out  32  aligned, extended load result.
REQ-017 SHALL have port stall_MEMEX  out  1  hold MEMEX and upstream; inject bubble into WB.
REQ-018 SHALL have port misaligned_MEMEX  out  1  misaligned access exception.
REQ-019 SHALL have port bus_fault_MEMEX  out  1  timeout exception, valid in DONE.

Function
REQ-020 SHALL implement states IDLE, BUSY, DONE.
REQ-021 "Access" SHALL mean invalid_MEMEX=0, mem_op 01/10, legal funct3 (loads: 5 codes; stores: 000/001/010), aligned.
REQ-022 Misaligned SHALL mean H/HU/SH with addr[0]=1, or W/SW with addr[1:0]!=00; misaligned_MEMEX=1 combinationally in IDLE, no access, stall 0.
REQ-023 Illegal funct3 or mem_op 00/11 SHALL issue no access, stall 0, no exception.
REQ-024 IDLE with access: stall_MEMEX=1 combinationally; capture addr, we, wdata, wstrb, funct3, addr[1:0]; next state BUSY.
REQ-025 BUSY: bus_req=1, bus outputs driven from captured registers, stable until exit; stall_MEMEX=1; watchdog increments each cycle.
REQ-026 BUSY with bus_ack=1: capture bus_rdata, clear watchdog, next DONE.
REQ-027 BUSY with watchdog = TIMEOUT_CYCLES and no ack: set fault flag, next DONE; ack in that same cycle takes priority (no fault).
REQ-028 DONE: bus_req=0, stall_MEMEX=0, load_data_MEMEX valid, bus_fault_MEMEX=fault flag; next IDLE unconditionally.
REQ-029 Min access latency SHALL be 3 cycles in MEMEX (IDLE, BUSY, DONE), 2 stall cycles.
REQ-030 Store lanes: SB wstrb=0001<<addr[1:0], wdata={4{data[7:0]}}; SH wstrb=0011<<(2*addr[1]), wdata={2{data[15:0]}}; SW 1111, data.
REQ-031 Load extract: byte = rdata>>(8*addr[1:0]), half = rdata>>(16*addr[1]); B/H sign-extend, BU/HU zero-extend, W pass-through.
REQ-032 load_data_MEMEX SHALL be 0 outside DONE and for stores.
REQ-033 bus_ack outside BUSY SHALL be ignored.
REQ-034 Input changes during BUSY SHALL NOT affect captured request.

Reset
REQ-035 rst=1 at posedge SHALL force IDLE, watchdog 0, fault flag 0, captured regs 0.
REQ-036 After reset all outputs SHALL be 0 (stall/misaligned follow inputs in IDLE combinationally).
REQ-037 Reset during BUSY SHALL drop bus_req the following cycle; a later stray ack SHALL be ignored.

Verification
REQ-038 LB addr 0x1003, rdata 0x80FF_0000, ack 1st BUSY cycle -> stall 2 cycles, bus_addr 0x1000, DONE load_data 0xFFFF_FF80.
REQ-039 SH addr 0x2002, data 0x0000_BEEF -> bus_we 1, wstrb 1100, wdata 0xBEEF_BEEF, bus_addr 0x2000.
REQ-040 LW addr 0x3001 -> misaligned_MEMEX 1, bus_req stays 0, stall 0.
REQ-041 LHU addr 0x4002, ack withheld, TIMEOUT_CYCLES=4 -> bus_req high 5 cycles, DONE bus_fault_MEMEX 1, load_data 0.
REQ-042 LW invalid_MEMEX=1 -> no bus_req, stall 0; then rst in BUSY of next LW -> bus_req 0 next cycle, ack 2 cycles later ignored.
